// File: rtl/dds_profile_sequencer.sv
// dds_profile_sequencer
// Steps the DDS profile pins (PS0..PS2) and ramp direction pin (DRCTL)
// through a small programmable table of {profile, direction, dwell} entries.
// Each entry stays on the pins for max(dwell,1) clock cycles. Whole passes
// over the table can repeat a fixed number of times or until aborted.
// hold_req freezes the current entry and drives DRHOLD.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cfg_we/addr/data    table write port, only accepted while idle
//                       data = {ps[2:0], drctl, dwell[DWELL_W-1:0]}
//   cfg_len, loop_cnt   entries per pass and pass count (0 = forever),
//                       latched when a sequence starts
//   start, abort        sequence control; abort wins over everything
//   hold_req            freeze the current entry while running
//   PS0..PS2, DRCTL     profile / ramp direction pins (registered)
//   DRHOLD              ramp hold pin, high only while a hold is active
//   busy, done          sequence running / one-cycle completion pulse
//   cur_idx             index of the entry currently on the pins
module dds_profile_sequencer #(
  parameter int DEPTH   = 8,
  parameter int DWELL_W = 24,
  parameter int AW      = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [AW-1:0]      cfg_addr,
  input  logic [DWELL_W+3:0] cfg_data,
  input  logic [AW:0]        cfg_len,
  input  logic [7:0]         loop_cnt,
  input  logic               start,
  input  logic               abort,
  input  logic               hold_req,
  output logic               PS0,
  output logic               PS1,
  output logic               PS2,
  output logic               DRCTL,
  output logic               DRHOLD,
  output logic               busy,
  output logic               done,
  output logic [AW-1:0]      cur_idx
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  logic [DWELL_W+3:0] table_q [DEPTH];

  state_t             state_q, state_d;
  logic [2:0]         ps_q, ps_d;
  logic               drctl_q, drctl_d;
  logic               drhold_q, drhold_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic [AW:0]        len_q, len_d;
  logic [7:0]         passes_q, passes_d;
  logic               forever_q, forever_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;

  logic               last_entry;
  logic [AW-1:0]      next_idx;
  logic [DWELL_W+3:0] next_entry;
  logic [DWELL_W-1:0] next_dwell;
  logic [AW:0]        len_sat;

  // The table is not reset: it keeps its programming across resets.
  always_ff @(posedge clk) begin
    if (cfg_we && (state_q == IDLE)) begin
      table_q[cfg_addr] <= cfg_data;
    end
  end

  // Entry that would be loaded on the next advance: entry0 when starting or
  // wrapping, otherwise the following entry. A zero dwell loads as 1 so the
  // entry still shows for one cycle.
  always_comb begin
    last_entry = ({1'b0, idx_q} == (len_q - {{AW{1'b0}}, 1'b1}));
    next_idx   = ((state_q == RUN) && !last_entry) ? idx_q + {{(AW-1){1'b0}}, 1'b1}
                                                   : '0;
    next_entry = table_q[next_idx];
    next_dwell = (next_entry[DWELL_W-1:0] == '0) ? DWELL_W'(1)
                                                 : next_entry[DWELL_W-1:0];
    len_sat    = (cfg_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : cfg_len;
  end

  // Next-state and registered-output logic. Priority inside RUN is
  // abort, then hold (freezes the dwell count), then dwell expiry.
  always_comb begin
    state_d   = state_q;
    ps_d      = ps_q;
    drctl_d   = drctl_q;
    drhold_d  = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    idx_d     = idx_q;
    len_d     = len_q;
    passes_d  = passes_q;
    forever_d = forever_q;
    cnt_d     = cnt_q;

    case (state_q)
      IDLE: begin
        if (!abort && start) begin
          if (cfg_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d   = RUN;
            len_d     = len_sat;
            passes_d  = loop_cnt;
            forever_d = (loop_cnt == 8'd0);
            idx_d     = '0;
            ps_d      = next_entry[DWELL_W+3:DWELL_W+1];
            drctl_d   = next_entry[DWELL_W];
            cnt_d     = next_dwell;
            busy_d    = 1'b1;
          end
        end
      end

      RUN: begin
        if (abort) begin
          state_d = IDLE;
          ps_d    = '0;
          drctl_d = 1'b0;
          busy_d  = 1'b0;
          idx_d   = '0;
        end else if (hold_req) begin
          drhold_d = 1'b1;
        end else if (cnt_q > DWELL_W'(1)) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else if (last_entry && !forever_q && (passes_q <= 8'd1)) begin
          state_d = FIN;
          ps_d    = '0;
          drctl_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          idx_d   = '0;
        end else begin
          if (last_entry && !forever_q) begin
            passes_d = passes_q - 8'd1;
          end
          idx_d   = next_idx;
          ps_d    = next_entry[DWELL_W+3:DWELL_W+1];
          drctl_d = next_entry[DWELL_W];
          cnt_d   = next_dwell;
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ps_q      <= '0;
      drctl_q   <= 1'b0;
      drhold_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      idx_q     <= '0;
      len_q     <= '0;
      passes_q  <= '0;
      forever_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ps_q      <= ps_d;
      drctl_q   <= drctl_d;
      drhold_q  <= drhold_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      passes_q  <= passes_d;
      forever_q <= forever_d;
      cnt_q     <= cnt_d;
    end
  end

  assign PS0     = ps_q[0];
  assign PS1     = ps_q[1];
  assign PS2     = ps_q[2];
  assign DRCTL   = drctl_q;
  assign DRHOLD  = drhold_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign cur_idx = idx_q;

endmodule

// File: tb/tb_dds_profile_sequencer.sv
// tb_dds_profile_sequencer
// Self-checking bench for dds_profile_sequencer. A reference model expands
// the programmed table into the expected per-cycle pin timeline (each entry
// repeated max(dwell,1) times, passes concatenated, then a done cycle). A
// sampled hold repeats the current pin state with DRHOLD set and delays the
// rest of the timeline; an abort ends it.
module tb_dds_profile_sequencer;

  localparam int DEPTH   = 8;
  localparam int DWELL_W = 24;
  localparam int AW      = 3;
  localparam int MAXC    = 400;

  logic               clk;
  logic               rst;
  logic               cfg_we;
  logic [AW-1:0]      cfg_addr;
  logic [DWELL_W+3:0] cfg_data;
  logic [AW:0]        cfg_len;
  logic [7:0]         loop_cnt;
  logic               start;
  logic               abort;
  logic               hold_req;
  logic               PS0, PS1, PS2, DRCTL, DRHOLD, busy, done;
  logic [AW-1:0]      cur_idx;

  typedef struct packed {
    logic [2:0] ps;
    logic       dr;
    logic       hold;
    logic       busy;
    logic       done;
    logic [2:0] idx;
  } obs_t;

  logic [2:0]         mPs [DEPTH];
  logic               mDr [DEPTH];
  int                 mDwell [DEPTH];
  obs_t               sched [$];
  obs_t               expv [MAXC];
  obs_t               obsv [MAXC];
  bit                 holdPat [MAXC];
  int                 abortAt;
  int                 wrAt;
  logic [AW-1:0]      wrAddr;
  logic [DWELL_W+3:0] wrData;
  int                 runLen;
  int                 runLoops;
  int                 checks;
  int                 errors;

  dds_profile_sequencer #(.DEPTH(DEPTH), .DWELL_W(DWELL_W), .AW(AW)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_len(cfg_len), .loop_cnt(loop_cnt),
    .start(start), .abort(abort), .hold_req(hold_req),
    .PS0(PS0), .PS1(PS1), .PS2(PS2), .DRCTL(DRCTL), .DRHOLD(DRHOLD),
    .busy(busy), .done(done), .cur_idx(cur_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t sample();
    obs_t o;
    o.ps   = {PS2, PS1, PS0};
    o.dr   = DRCTL;
    o.hold = DRHOLD;
    o.busy = busy;
    o.done = done;
    o.idx  = cur_idx;
    return o;
  endfunction

  // Program one entry while the sequencer is idle and mirror it in the model.
  task automatic write_entry(input int a, input int ps, input int dr, input int d);
    logic [2:0]         psv;
    logic [DWELL_W-1:0] dv;
    psv = ps[2:0];
    dv  = d[DWELL_W-1:0];
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = a[AW-1:0];
    cfg_data = {psv, dr[0], dv};
    @(negedge clk);
    cfg_we = 1'b0;
    mPs[a]    = psv;
    mDr[a]    = dr[0];
    mDwell[a] = d;
  endtask

  task automatic clear_stim();
    for (int i = 0; i < MAXC; i++) holdPat[i] = 1'b0;
    abortAt = -1;
    wrAt    = -1;
  endtask

  // Expected pin timeline without holds or aborts.
  task automatic model_sequence(input int n);
    int   len;
    int   passes;
    int   rep;
    obs_t e;
    sched.delete();
    len = (runLen > DEPTH) ? DEPTH : runLen;
    if (len == 0) begin
      e = '0;
      e.done = 1'b1;
      sched.push_back(e);
      return;
    end
    passes = (runLoops == 0) ? 1000000 : runLoops;
    for (int p = 0; p < passes && sched.size() < n; p++) begin
      for (int k = 0; k < len; k++) begin
        rep = (mDwell[k] == 0) ? 1 : mDwell[k];
        for (int r = 0; r < rep; r++) begin
          e = '0;
          e.ps   = mPs[k];
          e.dr   = mDr[k];
          e.busy = 1'b1;
          e.idx  = k[2:0];
          sched.push_back(e);
        end
      end
    end
    if (runLoops != 0) begin
      e = '0;
      e.done = 1'b1;
      sched.push_back(e);
    end
  endtask

  // Apply holds and abort to the timeline to get the per-cycle expectation.
  task automatic predict(input int n);
    obs_t cur;
    cur = '0;
    for (int c = 0; c < n; c++) begin
      if (c == 0) begin
        cur = (sched.size() > 0) ? sched.pop_front() : obs_t'(0);
      end else if (abortAt >= 0 && c - 1 == abortAt) begin
        cur = '0;
        sched.delete();
      end else if (holdPat[c-1] && cur.busy) begin
        cur.hold = 1'b1;
      end else begin
        cur = (sched.size() > 0) ? sched.pop_front() : obs_t'(0);
      end
      expv[c] = cur;
    end
  endtask

  // Pulse start, then record n cycles of outputs. The configuration inputs
  // are scrambled after start to show that they were latched.
  task automatic drive_run(input int n);
    @(negedge clk);
    cfg_len  = runLen[AW:0];
    loop_cnt = runLoops[7:0];
    start    = 1'b1;
    hold_req = 1'b0;
    abort    = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (c == 0) begin
        start    = 1'b0;
        cfg_len  = 4'($urandom);
        loop_cnt = 8'($urandom);
      end
      obsv[c]  = sample();
      hold_req = holdPat[c];
      abort    = (c == abortAt);
      cfg_we   = (c == wrAt);
      if (c == wrAt) begin
        cfg_addr = wrAddr;
        cfg_data = wrData;
      end
    end
    @(negedge clk);
    hold_req = 1'b0;
    abort    = 1'b0;
    cfg_we   = 1'b0;
  endtask

  task automatic load_basic_table();
    write_entry(0, 1, 0, 4);
    write_entry(1, 5, 1, 2);
    write_entry(2, 7, 0, 0);
  endtask

  task automatic test_reset();
    obs_t o;
    repeat (2) @(negedge clk);
    o = sample();
    checks++;
    if (o !== obs_t'(0)) begin
      errors++;
      $display("[TB] FAIL reset_held: got %h expected %h", o, obs_t'(0));
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    o = sample();
    checks++;
    if (o !== obs_t'(0)) begin
      errors++;
      $display("[TB] FAIL reset_released: got %h expected %h", o, obs_t'(0));
    end
  endtask

  task automatic test_basic();
    clear_stim();
    load_basic_table();
    runLen = 3; runLoops = 1;
    model_sequence(12); predict(12); drive_run(12);
    for (int c = 0; c < 12; c++) begin
      checks++;
      if (obsv[c] !== expv[c]) begin
        errors++;
        $display("[TB] FAIL basic c%0d: got %h expected %h", c, obsv[c], expv[c]);
      end
    end
    checks++;
    if (obsv[7].done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_done_at7: got %b expected 1", obsv[7].done);
    end
  endtask

  task automatic test_loop2();
    clear_stim();
    runLen = 3; runLoops = 2;
    model_sequence(20); predict(20); drive_run(20);
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (obsv[c] !== expv[c]) begin
        errors++;
        $display("[TB] FAIL loop2 c%0d: got %h expected %h", c, obsv[c], expv[c]);
      end
    end
    checks++;
    if (obsv[14].done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL loop2_done_at14: got %b expected 1", obsv[14].done);
    end
  endtask

  task automatic test_hold();
    int holdCycles;
    int e0Cycles;
    clear_stim();
    for (int c = 2; c < 7; c++) holdPat[c] = 1'b1;
    runLen = 3; runLoops = 1;
    model_sequence(20); predict(20); drive_run(20);
    holdCycles = 0;
    e0Cycles   = 0;
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (obsv[c] !== expv[c]) begin
        errors++;
        $display("[TB] FAIL hold c%0d: got %h expected %h", c, obsv[c], expv[c]);
      end
      if (obsv[c].hold) holdCycles++;
      if (obsv[c].busy && obsv[c].idx == 3'd0) e0Cycles++;
    end
    checks++;
    if (holdCycles != 5) begin
      errors++;
      $display("[TB] FAIL hold_count: got %0d expected 5", holdCycles);
    end
    checks++;
    if (e0Cycles != 9) begin
      errors++;
      $display("[TB] FAIL hold_entry0_len: got %0d expected 9", e0Cycles);
    end
  endtask

  task automatic test_infinite_abort();
    int doneSeen;
    clear_stim();
    abortAt = 19;
    runLen = 3; runLoops = 0;
    model_sequence(30); predict(30); drive_run(30);
    doneSeen = 0;
    for (int c = 0; c < 30; c++) begin
      checks++;
      if (obsv[c] !== expv[c]) begin
        errors++;
        $display("[TB] FAIL abort c%0d: got %h expected %h", c, obsv[c], expv[c]);
      end
      if (obsv[c].done) doneSeen++;
    end
    checks++;
    if (doneSeen != 0) begin
      errors++;
      $display("[TB] FAIL abort_no_done: got %0d pulses expected 0", doneSeen);
    end
  endtask

  task automatic test_write_while_busy();
    clear_stim();
    wrAt   = 3;
    wrAddr = '0;
    wrData = {3'd3, 1'b0, 24'd4};
    runLen = 3; runLoops = 1;
    model_sequence(12); predict(12); drive_run(12);
    clear_stim();
    model_sequence(12); predict(12); drive_run(12);
    for (int c = 0; c < 12; c++) begin
      checks++;
      if (obsv[c] !== expv[c]) begin
        errors++;
        $display("[TB] FAIL wrbusy_rerun c%0d: got %h expected %h", c, obsv[c], expv[c]);
      end
    end
    checks++;
    if (obsv[0].ps !== 3'd1) begin
      errors++;
      $display("[TB] FAIL wrbusy_entry0_ps: got %0d expected 1", obsv[0].ps);
    end
    clear_stim();
    runLen = 0; runLoops = 1;
    model_sequence(4); predict(4); drive_run(4);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (obsv[c] !== expv[c]) begin
        errors++;
        $display("[TB] FAIL len0 c%0d: got %h expected %h", c, obsv[c], expv[c]);
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    obs_t e1;
    e1 = '0;
    e1.ps = 3'd5; e1.dr = 1'b1; e1.busy = 1'b1; e1.idx = 3'd1;
    @(negedge clk);
    cfg_len = 4'd3; loop_cnt = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    o = sample();
    checks++;
    if (o !== e1) begin
      errors++;
      $display("[TB] FAIL rstmid_entry1: got %h expected %h", o, e1);
    end
    #2 rst = 1'b1;
    #1 o = sample();
    checks++;
    if (o !== obs_t'(0)) begin
      errors++;
      $display("[TB] FAIL rstmid_async: got %h expected %h", o, obs_t'(0));
    end
    @(negedge clk);
    rst = 1'b0;
    clear_stim();
    runLen = 3; runLoops = 1;
    model_sequence(12); predict(12); drive_run(12);
    for (int c = 0; c < 12; c++) begin
      checks++;
      if (obsv[c] !== expv[c]) begin
        errors++;
        $display("[TB] FAIL rstmid_replay c%0d: got %h expected %h", c, obsv[c], expv[c]);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      clear_stim();
      for (int k = 0; k < DEPTH; k++) begin
        write_entry(k, $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 4));
      end
      runLen   = $urandom_range(0, 11);
      runLoops = $urandom_range(0, 3);
      for (int c = 0; c < 200; c++) holdPat[c] = ($urandom_range(0, 4) == 0);
      if (runLoops == 0) abortAt = $urandom_range(5, 60);
      else if ($urandom_range(0, 3) == 0) abortAt = $urandom_range(0, 40);
      model_sequence(200); predict(200); drive_run(200);
      for (int c = 0; c < 200; c++) begin
        checks++;
        if (obsv[c] !== expv[c]) begin
          errors++;
          $display("[TB] FAIL random it%0d c%0d: got %h expected %h", it, c, obsv[c], expv[c]);
        end
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    cfg_we   = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
    cfg_len  = '0;
    loop_cnt = '0;
    start    = 1'b0;
    abort    = 1'b0;
    hold_req = 1'b0;
    checks   = 0;
    errors   = 0;
    for (int k = 0; k < DEPTH; k++) begin
      mPs[k] = '0; mDr[k] = 1'b0; mDwell[k] = 0;
    end
    clear_stim();
    test_reset();
    test_basic();
    test_loop2();
    test_hold();
    test_infinite_abort();
    test_write_while_busy();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
